// File: rtl/instr_inject_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_inject_pkg
// Brief   : Shared types for the external-instruction injection controller.
// Rev     : 1.0
// ============================================================================
package instr_inject_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INJECT = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic        last;
      logic [31:0] instr;
   } inj_entry_t;

endpackage
`default_nettype wire

// File: rtl/inject_fifo.sv
`default_nettype none
// ============================================================================
// Module  : inject_fifo
// Brief   : Instruction FIFO with a one-entry read-pointer rewind for replay.
// Rev     : 1.0
// ============================================================================
module inject_fifo
   import instr_inject_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int RESERVE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  inj_entry_t push_data,
   input  logic       pop,
   input  logic       rewind,
   output inj_entry_t head,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH - RESERVE);

   inj_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Rewinding re-exposes the entry just popped; the reserved slot keeps it intact.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end else if (rewind) begin
            rd_ptr <= rd_ptr - AW'(1);
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop) + (AW+1)'(rewind);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/instr_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_inject_ctrl
// Brief   : Feeds a buffered host program into the core's external fetch path,
//           then drains it with NOPs. Optional flush replay: INSTR_INJECT_FLUSH_REPLAY_EN.
// Rev     : 1.0
// ============================================================================
module instr_inject_ctrl
   import instr_inject_pkg::*;
#(
   parameter int          DEPTH      = 8,
   parameter int          DRAIN_NOPS = 5,
   parameter int          CNT_W      = 16,
   parameter logic [31:0] NOP        = NOP_INSTR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic             in_last,
   input  logic             fetch_stall,
   input  logic             fetch_flush,
   output logic             instr_mode,
   output logic [31:0]      instr_ext,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] issued_cnt
);

`ifdef INSTR_INJECT_FLUSH_REPLAY_EN
   localparam bit REPLAY = 1'b1;
`else
   localparam bit REPLAY = 1'b0;
`endif
   localparam int RESERVE = REPLAY ? 1 : 0;
   localparam int NW      = (DRAIN_NOPS > 0) ? $clog2(DRAIN_NOPS + 1) : 1;

   state_t     state;
   state_t     state_nx;
   logic [NW-1:0] nop_cnt;
   logic       prev_issue;
   inj_entry_t head;
   inj_entry_t wr_entry;
   logic       fifo_empty;
   logic       fifo_full;
   logic       push;
   logic       issue;
   logic       rewind;

   assign wr_entry.last  = in_last;
   assign wr_entry.instr = in_instr;
   assign push = in_valid && in_ready;

   // A flush squashes whatever was issued last cycle; it is replayed instead of popping.
   assign rewind = REPLAY && fetch_flush && prev_issue &&
                   ((state == INJECT) || (state == DRAIN));
   assign issue  = (state == INJECT) && instr_mode && !fetch_stall &&
                   !fifo_empty && !rewind;

   inject_fifo #(
      .DEPTH   (DEPTH),
      .RESERVE (RESERVE)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (wr_entry),
      .pop       (issue),
      .rewind    (rewind),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      instr_ext = NOP;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !fifo_full;
            if (start) begin
               state_nx = INJECT;
            end
         end
         INJECT: begin
            in_ready = !fifo_full;
            busy     = 1'b1;
            if (!fifo_empty) begin
               instr_ext = head.instr;
            end
            if (issue && head.last) begin
               if (DRAIN_NOPS == 0) begin
                  state_nx = DONE;
               end else begin
                  state_nx = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (rewind) begin
               state_nx = INJECT;
            end else if (!fetch_stall && (nop_cnt == NW'(1))) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nx = INJECT;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      if (!reset) begin
         in_ready = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_mode <= 1'b0;
         issued_cnt <= '0;
         nop_cnt    <= '0;
         prev_issue <= 1'b0;
      end else begin
         prev_issue <= issue;
         if ((state == IDLE) && start) begin
            instr_mode <= 1'b1;
         end
         if ((state == DONE) && start) begin
            issued_cnt <= '0;
         end else if (issue) begin
            if (issued_cnt != '1) begin
               issued_cnt <= issued_cnt + CNT_W'(1);
            end
         end else if (rewind) begin
            issued_cnt <= issued_cnt - CNT_W'(1);
         end
         if (issue && head.last) begin
            nop_cnt <= NW'(DRAIN_NOPS);
         end else if ((state == DRAIN) && !fetch_stall && (nop_cnt != '0)) begin
            nop_cnt <= nop_cnt - NW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_inject_ctrl
// Brief   : Directed self-checking bench for instr_inject_ctrl.
// Rev     : 1.0
// ============================================================================
module tb_instr_inject_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0050_0093;
   localparam logic [31:0] I1  = 32'h00A0_0113;
   localparam logic [31:0] I2  = 32'h0020_81B3;
`ifdef INSTR_INJECT_FLUSH_REPLAY_EN
   localparam int LIMIT = 7;
`else
   localparam int LIMIT = 8;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic        in_last = 1'b0;
   logic        fetch_stall = 1'b0;
   logic        fetch_flush = 1'b0;
   logic        instr_mode;
   logic [31:0] instr_ext;
   logic        busy;
   logic        done;
   logic [15:0] issued_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   instr_inject_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_last     (in_last),
      .fetch_stall (fetch_stall),
      .fetch_flush (fetch_flush),
      .instr_mode  (instr_mode),
      .instr_ext   (instr_ext),
      .busy        (busy),
      .done        (done),
      .issued_cnt  (issued_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      fetch_stall = 1'b0; fetch_flush = 1'b0;
      cyc(); cyc();
      reset = 1'b1;
      cyc();
   endtask

   task automatic push_one(input logic [31:0] ins, input logic last);
      int n = 0;
      in_valid = 1'b1; in_instr = ins; in_last = last;
      #1;
      while (!in_ready && n < 20) begin cyc(); n++; end
      check("push_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin cyc(); n++; end
      check("done_reached", done, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_seq [8];

      // reset state
      cyc();
      check("rst_in_ready", in_ready, 0);
      check("rst_mode", instr_mode, 0);
      check("rst_ext", instr_ext, NOP);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", issued_cnt, 0);

      // basic stream: three instructions, then five drain NOPs
      do_reset();
      check("idle_ready", in_ready, 1);
      push_one(I0, 1'b0);
      push_one(I1, 1'b0);
      push_one(I2, 1'b1);
      pulse_start();
      check("basic_mode", instr_mode, 1);
      check("basic_busy", busy, 1);
      exp_seq = '{I0, I1, I2, NOP, NOP, NOP, NOP, NOP};
      for (int k = 0; k < 8; k++) begin
         check($sformatf("basic_ext%0d", k), instr_ext, exp_seq[k]);
         check($sformatf("basic_done%0d", k), done, 0);
         cyc();
      end
      check("basic_done", done, 1);
      check("basic_busy_end", busy, 0);
      check("basic_cnt", issued_cnt, 3);
      check("basic_ext_done", instr_ext, NOP);
      check("basic_ready_done", in_ready, 0);

      // stall hold
      do_reset();
      push_one(I0, 1'b0);
      push_one(I1, 1'b0);
      push_one(I2, 1'b1);
      pulse_start();
      check("stall_ext0", instr_ext, I0);
      cyc();
      fetch_stall = 1'b1;
      #1;
      check("stall_ext1", instr_ext, I1);
      check("stall_cnt1", issued_cnt, 1);
      cyc();
      check("stall_ext2", instr_ext, I1);
      check("stall_cnt2", issued_cnt, 1);
      cyc();
      fetch_stall = 1'b0;
      #1;
      check("stall_ext3", instr_ext, I1);
      check("stall_cnt3", issued_cnt, 1);
      cyc();
      check("stall_ext4", instr_ext, I2);
      check("stall_cnt4", issued_cnt, 2);
      wait_done();
      check("stall_cnt_end", issued_cnt, 3);

      // full FIFO: the entry after the limit is refused
      do_reset();
      for (int k = 0; k < 9; k++) begin
         in_valid = 1'b1;
         in_instr = 32'h100 + k;
         in_last  = (k == LIMIT - 1);
         #1;
         check($sformatf("full_ready%0d", k), in_ready, (k < LIMIT) ? 1 : 0);
         cyc();
      end
      in_valid = 1'b0; in_last = 1'b0;
      pulse_start();
      for (int k = 0; k < LIMIT; k++) begin
         check($sformatf("full_ext%0d", k), instr_ext, 32'h100 + k);
         cyc();
      end
      check("full_drain_nop", instr_ext, NOP);
      wait_done();
      check("full_cnt", issued_cnt, LIMIT);

      // empty bubble between entries
      do_reset();
      push_one(I0, 1'b0);
      pulse_start();
      check("bub_ext0", instr_ext, I0);
      cyc();
      check("bub_ext1", instr_ext, NOP);
      check("bub_busy1", busy, 1);
      check("bub_cnt1", issued_cnt, 1);
      cyc();
      check("bub_ext2", instr_ext, NOP);
      cyc();
      in_valid = 1'b1; in_instr = I1; in_last = 1'b1;
      #1;
      check("bub_ext3", instr_ext, NOP);
      check("bub_ready3", in_ready, 1);
      cyc();
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      check("bub_ext4", instr_ext, I1);
      check("bub_cnt4", issued_cnt, 1);
      wait_done();
      check("bub_cnt_end", issued_cnt, 2);

      // restart from DONE clears the count
      pulse_start();
      check("restart_done", done, 0);
      check("restart_cnt", issued_cnt, 0);
      check("restart_busy", busy, 1);

`ifdef INSTR_INJECT_FLUSH_REPLAY_EN
      // flush replay
      do_reset();
      push_one(I0, 1'b0);
      push_one(I1, 1'b1);
      pulse_start();
      check("fl_ext0", instr_ext, I0);
      cyc();
      fetch_flush = 1'b1;
      #1;
      check("fl_cnt1", issued_cnt, 1);
      cyc();
      fetch_flush = 1'b0;
      #1;
      check("fl_ext2", instr_ext, I0);
      check("fl_cnt2", issued_cnt, 0);
      cyc();
      check("fl_ext3", instr_ext, I1);
      wait_done();
      check("fl_cnt_end", issued_cnt, 2);
`endif

      // reset in DRAIN with an entry still buffered
      do_reset();
      push_one(I0, 1'b1);
      push_one(I1, 1'b0);
      pulse_start();
      check("mr_ext0", instr_ext, I0);
      cyc();
      check("mr_busy_drain", busy, 1);
      check("mr_ext_drain", instr_ext, NOP);
      reset = 1'b0;
      cyc();
      check("mr_mode", instr_mode, 0);
      check("mr_ext", instr_ext, NOP);
      check("mr_done", done, 0);
      check("mr_cnt", issued_cnt, 0);
      check("mr_busy", busy, 0);
      check("mr_ready", in_ready, 0);
      reset = 1'b1;
      cyc();
      pulse_start();
      check("mr_empty_ext", instr_ext, NOP);
      cyc();
      check("mr_empty_ext2", instr_ext, NOP);
      check("mr_empty_cnt", issued_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
